// File: rtl/ggt_job_scheduler_if.sv
// Signal bundle between the ggT job scheduler, its producer, the ggT core and the result consumer.
// The scheduler takes the slave view; whatever surrounds it takes the master view.
interface ggt_job_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [WIDTH-1:0]  in_zahl1_i;
  logic [WIDTH-1:0]  in_zahl2_i;

  logic              core_start_o;
  logic [WIDTH-1:0]  core_zahl1_o;
  logic [WIDTH-1:0]  core_zahl2_o;
  logic              core_valid_i;
  logic [WIDTH-1:0]  core_ergebnis_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [WIDTH-1:0]  out_zahl1_o;
  logic [WIDTH-1:0]  out_zahl2_o;
  logic [WIDTH-1:0]  out_ergebnis_o;
  logic              out_timeout_o;

  logic              busy_o;
  logic [FILL_W-1:0] fill_o;

  modport slave (
    input  in_valid_i, in_zahl1_i, in_zahl2_i, core_valid_i, core_ergebnis_i, out_ready_i,
    output in_ready_o, core_start_o, core_zahl1_o, core_zahl2_o,
           out_valid_o, out_zahl1_o, out_zahl2_o, out_ergebnis_o, out_timeout_o,
           busy_o, fill_o
  );

  modport master (
    output in_valid_i, in_zahl1_i, in_zahl2_i, core_valid_i, core_ergebnis_i, out_ready_i,
    input  in_ready_o, core_start_o, core_zahl1_o, core_zahl2_o,
           out_valid_o, out_zahl1_o, out_zahl2_o, out_ergebnis_o, out_timeout_o,
           busy_o, fill_o
  );
endinterface

// File: rtl/ggt_job_scheduler.sv
// Feeds operand pairs from a small FIFO to the ggT core one job at a time, resolves zero
// operands locally, aborts hung jobs after TIMEOUT_CYCLES and returns results in push order.
module ggt_job_scheduler #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic               clk,
  input logic               rst_ni,
  ggt_job_scheduler_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               rdy_q;
  logic               full, empty, push, pop;
  logic [WIDTH-1:0]   head_z1, head_z2;

  logic [2:0]         state;
  logic [WIDTH-1:0]   op1, op2, result;
  logic               timed_out;
  logic [TW-1:0]      timer;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = bus.in_valid_i && bus.in_ready_o;
  assign pop     = (state == S_IDLE) && !empty;
  assign head_z1 = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign head_z2 = mem[rd_ptr][WIDTH-1:0];

  // Held low through reset so no pair is accepted before the first clock after release.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  // NOTE: the storage array is deliberately not reset; count alone says which entries are
  // live, so stale contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_zahl1_i, bus.in_zahl2_i};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      op1       <= '0;
      op2       <= '0;
      result    <= '0;
      timed_out <= 1'b0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            op1 <= head_z1;
            op2 <= head_z2;
            // ggT(x,0) = x and ggT(0,0) = 0 are both just the OR of the operands.
            if (head_z1 == '0 || head_z2 == '0) begin
              result    <= head_z1 | head_z2;
              timed_out <= 1'b0;
              state     <= S_OUT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_GUARD;
        S_GUARD: begin
          // The core's valid may still be high from the previous job here, so it is not looked at.
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (timer != '1) timer <= timer + 1'b1;
          if (bus.core_valid_i) begin
            result    <= bus.core_ergebnis_i;
            timed_out <= 1'b0;
            state     <= S_OUT;
          end else if (timer == TIMER_LAST) begin
            result    <= '0;
            timed_out <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o     = rdy_q && !full;
  assign bus.core_start_o   = (state == S_ISSUE);
  assign bus.core_zahl1_o   = op1;
  assign bus.core_zahl2_o   = op2;
  assign bus.out_valid_o    = (state == S_OUT);
  assign bus.out_zahl1_o    = op1;
  assign bus.out_zahl2_o    = op2;
  assign bus.out_ergebnis_o = result;
  assign bus.out_timeout_o  = timed_out;
  assign bus.busy_o         = (state != S_IDLE);
  assign bus.fill_o         = count;

endmodule

// File: tb/tb_ggt_job_scheduler.sv
// Self-checking bench: job-level timing model plus a ggT core model, directed scenarios
// with literal expectations, then a randomized stream with random backpressure.
module tb_ggt_job_scheduler;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct {
    logic [WIDTH-1:0] z1, z2, erg, junk;
    int               d;
    bit               hang, stale, to;
  } job_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  ggt_job_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ggt_job_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state, valid for the cycle currently on the bus.
  job_t m_q[$];
  job_t m_job;
  bit   m_active = 1'b0;
  bit   m_rdy = 1'b0;
  int   m_start, m_out;
  int   out_cnt = 0, start_cnt = 0, last_start = 0, dut_out_cycles = 0;
  job_t cfg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int x = int'(a), y = int'(b), t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return WIDTH'(x);
  endfunction

  function automatic bit is_zero_job(input job_t j);
    return (j.z1 == '0) || (j.z2 == '0);
  endfunction

  // Compare process: checks every cycle at the falling edge, then advances the model.
  initial begin
    job_t j;
    bit   exp_valid, acc;
    forever begin
      @(negedge clk);
      if (bus.out_valid_o === 1'b1) dut_out_cycles++;
      if (bus.core_start_o === 1'b1) begin
        start_cnt++;
        last_start = cyc;
      end
      if (!rst_ni) begin
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_core_start", bus.core_start_o, 0);
        check("rst_in_ready", bus.in_ready_o, 0);
        check("rst_fill", bus.fill_o, 0);
        check("rst_out_data", {bus.out_zahl1_o, bus.out_zahl2_o, bus.out_ergebnis_o, bus.out_timeout_o}, 0);
        check("rst_core_data", {bus.core_zahl1_o, bus.core_zahl2_o}, 0);
        m_q.delete();
        m_active = 1'b0;
        m_rdy = 1'b0;
      end else begin
        exp_valid = m_active && (cyc >= m_out);
        check("fill", bus.fill_o, m_q.size());
        check("in_ready", bus.in_ready_o, m_rdy && (m_q.size() < DEPTH));
        check("busy", bus.busy_o, m_active);
        check("core_start", bus.core_start_o, m_active && !is_zero_job(m_job) && (cyc == m_start));
        check("out_valid", bus.out_valid_o, exp_valid);
        if (m_active) check("core_operands", {bus.core_zahl1_o, bus.core_zahl2_o}, {m_job.z1, m_job.z2});
        if (exp_valid) begin
          check("out_operands", {bus.out_zahl1_o, bus.out_zahl2_o}, {m_job.z1, m_job.z2});
          check("out_ergebnis", bus.out_ergebnis_o, m_job.erg);
          check("out_timeout", bus.out_timeout_o, m_job.to);
        end
        // Advance to the next cycle from this cycle's inputs.
        acc = bus.in_valid_i && m_rdy && (m_q.size() < DEPTH);
        if (exp_valid && bus.out_ready_i) begin
          m_active = 1'b0;
          out_cnt++;
        end else if (!m_active && m_q.size() > 0) begin
          m_job    = m_q.pop_front();
          m_active = 1'b1;
          m_start  = cyc + 1;
          if (is_zero_job(m_job)) m_out = cyc + 1;
          else if (m_job.hang)    m_out = cyc + 3 + TO;
          else                    m_out = cyc + 4 + m_job.d;
        end
        if (acc) begin
          j       = cfg;
          j.z1    = bus.in_zahl1_i;
          j.z2    = bus.in_zahl2_i;
          if (is_zero_job(j)) begin
            j.erg = j.z1 | j.z2;
            j.to  = 1'b0;
          end else if (j.hang) begin
            j.erg = '0;
            j.to  = 1'b1;
          end else begin
            j.erg = gcd(j.z1, j.z2);
            j.to  = 1'b0;
          end
          j.junk = ~j.erg;
          m_q.push_back(j);
        end
        m_rdy = 1'b1;
      end
    end
  end

  // ggT core model: reacts to the start pulse using the job the model says is running.
  initial begin
    job_t j;
    bit   done;
    bus.core_valid_i    = 1'b0;
    bus.core_ergebnis_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        bus.core_valid_i    = 1'b0;
        bus.core_ergebnis_i = '0;
      end else if (bus.core_start_o === 1'b1) begin
        j = m_job;
        if (j.stale) begin
          bus.core_valid_i    = 1'b1;
          bus.core_ergebnis_i = j.junk;
        end else begin
          bus.core_valid_i = 1'b0;
        end
        @(posedge clk);
        #1;
        done = !rst_ni;
        for (int k = 0; k < TO && !done; k++) begin
          @(posedge clk);
          #1;
          if (!rst_ni) begin
            done = 1'b1;
          end else if (!j.hang && k == j.d) begin
            bus.core_valid_i    = 1'b1;
            bus.core_ergebnis_i = gcd(j.z1, j.z2);
            done = 1'b1;
          end else begin
            bus.core_valid_i = 1'b0;
          end
        end
        if (!rst_ni) bus.core_valid_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int d,
                      input bit hang, input bit stale, output bit acc, output int pcyc);
    bus.in_valid_i = 1'b1;
    bus.in_zahl1_i = a;
    bus.in_zahl2_i = b;
    cfg.d = d;
    cfg.hang = hang;
    cfg.stale = stale;
    pcyc = cyc;
    @(negedge clk);
    acc = bus.in_ready_o;
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  // Leaves the caller at the falling edge of the first cycle with out_valid_o high.
  task automatic wait_out(input int max, input string name, output int ocyc);
    bit found = 1'b0;
    ocyc = -1;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid_o === 1'b1) begin
        found = 1'b1;
        ocyc = cyc;
      end
    end
    check(name, found, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit acc;
    int pc, oc, n, s0, o0, hang_start;
    bus.in_valid_i = 1'b0;
    bus.in_zahl1_i = '0;
    bus.in_zahl2_i = '0;
    bus.out_ready_i = 1'b0;
    cfg = '{default: 0};
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    tick();
    @(negedge clk);
    check("ready_after_release", bus.in_ready_o, 1);
    check("fill_after_release", bus.fill_o, 0);
    tick();

    // Normal job
    bus.out_ready_i = 1'b1;
    s0 = start_cnt;
    push(16'd24255, 16'd12540, 10, 1'b0, 1'b0, acc, pc);
    check("t1_accepted", acc, 1);
    wait_out(60, "t1_out_seen", oc);
    check("t1_start_latency", last_start - pc, 2);
    check("t1_start_pulses", start_cnt - s0, 1);
    check("t1_zahl1", bus.out_zahl1_o, 24255);
    check("t1_zahl2", bus.out_zahl2_o, 12540);
    check("t1_ergebnis", bus.out_ergebnis_o, 165);
    check("t1_timeout", bus.out_timeout_o, 0);
    tick();
    repeat (3) tick();

    // Zero bypass
    s0 = start_cnt;
    push(16'd0, 16'd36, 0, 1'b0, 1'b0, acc, pc);
    wait_out(20, "t2a_out_seen", oc);
    check("t2a_latency", oc - pc, 2);
    check("t2a_ergebnis", bus.out_ergebnis_o, 36);
    tick();
    push(16'd0, 16'd0, 0, 1'b0, 1'b0, acc, pc);
    wait_out(20, "t2b_out_seen", oc);
    check("t2b_ergebnis", bus.out_ergebnis_o, 0);
    check("t2b_timeout", bus.out_timeout_o, 0);
    tick();
    check("t2_no_start", start_cnt - s0, 0);

    // Backpressure: one job parked in OUT, four in the FIFO, sixth push refused
    bus.out_ready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      push(WIDTH'((i + 1) * 12), WIDTH'((i + 1) * 18), 2, 1'b0, 1'b0, acc, pc);
      n += int'(acc);
    end
    repeat (8) tick();
    @(negedge clk);
    check("t3_accepted", n, 5);
    check("t3_in_ready_full", bus.in_ready_o, 0);
    check("t3_fill_full", bus.fill_o, 4);
    tick();
    o0 = out_cnt;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 200 && (out_cnt - o0) < 5; i++) tick();
    check("t3_drained", out_cnt - o0, 5);

    // Timeout, then a normal job behind it
    push(16'd5, 16'd10, 0, 1'b1, 1'b0, acc, pc);
    push(16'd12, 16'd18, 2, 1'b0, 1'b0, acc, pc);
    wait_out(60, "t4a_out_seen", oc);
    hang_start = last_start;
    check("t4a_wait_cycles", oc - hang_start - 2, TO);
    check("t4a_ergebnis", bus.out_ergebnis_o, 0);
    check("t4a_timeout", bus.out_timeout_o, 1);
    tick();
    wait_out(60, "t4b_out_seen", oc);
    check("t4b_ergebnis", bus.out_ergebnis_o, 6);
    check("t4b_timeout", bus.out_timeout_o, 0);
    tick();

    // Stale valid through ISSUE and GUARD
    push(16'd14, 16'd21, 3, 1'b0, 1'b1, acc, pc);
    wait_out(60, "t5_out_seen", oc);
    check("t5_ergebnis", bus.out_ergebnis_o, 7);
    check("t5_timeout", bus.out_timeout_o, 0);
    tick();

    // Reset in WAIT with three pairs queued
    bus.out_ready_i = 1'b0;
    push(16'd9, 16'd12, 0, 1'b1, 1'b0, acc, pc);
    push(16'd3, 16'd9, 1, 1'b0, 1'b0, acc, pc);
    push(16'd4, 16'd8, 1, 1'b0, 1'b0, acc, pc);
    push(16'd5, 16'd10, 1, 1'b0, 1'b0, acc, pc);
    repeat (4) tick();
    @(negedge clk);
    check("t6_fill_before_reset", bus.fill_o, 3);
    check("t6_busy_before_reset", bus.busy_o, 1);
    tick();
    #2 rst_ni = 1'b0;
    @(negedge clk);
    check("t6_busy_in_reset", bus.busy_o, 0);
    check("t6_fill_in_reset", bus.fill_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    @(negedge clk);
    check("t6_ready_after_release", bus.in_ready_o, 1);
    tick();
    o0 = dut_out_cycles;
    bus.out_ready_i = 1'b1;
    repeat (40) tick();
    check("t6_no_dropped_output", dut_out_cycles - o0, 0);

    // Randomized stream with random backpressure and core behaviour
    for (int i = 0; i < 3000; i++) begin
      int g, sel;
      g   = $urandom_range(1, 300);
      sel = $urandom_range(0, 19);
      bus.in_valid_i  = ($urandom_range(0, 2) != 0);
      bus.in_zahl1_i  = (sel == 0 || sel == 2) ? '0 : WIDTH'(g * $urandom_range(1, 200));
      bus.in_zahl2_i  = (sel == 1 || sel == 2) ? '0 : WIDTH'(g * $urandom_range(1, 200));
      cfg.d           = $urandom_range(0, TO - 1);
      cfg.hang        = ($urandom_range(0, 9) == 0);
      cfg.stale       = $urandom_range(0, 1) != 0;
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 2000 && (m_active || m_q.size() > 0); i++) tick();
    check("random_drained", m_active || (m_q.size() > 0), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
